fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage pipeline, sitting directly upstream of the hazard unit. It owns the PC and the instruction-cache request handshake, and it drives the IF/ID pipeline register that the hazard unit reads. It obeys the hazard unit's `ifid_en` / `ifid_flush` controls and redirects the PC on a taken jump or branch resolved in EX/MEM. A one-entry holding buffer ensures that an instruction returned during a stall is never refetched.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, the I-cache request handshake and the IF/ID register.
// A one-entry buffer holds an instruction returned during a stall so it is never refetched.
module fetch_unit #(
  parameter int unsigned         WORD_W  = 32,
  parameter logic [WORD_W-1:0]   PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ifid_en,
  input  logic              ifid_flush,
  input  logic              mem_stall,
  input  logic [2:0]        exmem_PCSrc,
  input  logic              exmem_ZeroFlag,
  input  logic [WORD_W-1:0] exmem_target,
  input  logic              halt,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_npc,
  output logic              ifid_valid,
  output logic [WORD_W-1:0] pc
);

  typedef enum logic [1:0] {StFetch, StDrain, StHalt} state_e;

  localparam logic [WORD_W-1:0] Four = WORD_W'(4);

  state_e            state;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] buf_instr;
  logic              buf_valid;

  logic              redir;
  logic              advance;
  logic              fetch_hit;
  logic [WORD_W-1:0] pc_plus4;

  always_comb begin
    redir = (exmem_PCSrc == 3'b001) ||
            ((exmem_PCSrc == 3'b010) && exmem_ZeroFlag) ||
            ((exmem_PCSrc == 3'b110) && !exmem_ZeroFlag);
    advance   = ifid_en && !mem_stall;
    pc_plus4  = pc + Four;
    fetch_hit = ihit && (state == StFetch) && !buf_valid;

    imemREN  = 1'b0;
    imemaddr = pc;
    unique case (state)
      StFetch: imemREN = !buf_valid;
      StDrain: begin
        // Keep the outstanding request stable until the cache answers.
        imemREN  = 1'b1;
        imemaddr = req_addr;
      end
      default: imemREN = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= StFetch;
      pc         <= PC_INIT;
      req_addr   <= '0;
      buf_instr  <= '0;
      buf_valid  <= 1'b0;
      ifid_instr <= '0;
      ifid_npc   <= '0;
      ifid_valid <= 1'b0;
    end else if (state == StHalt) begin
      ifid_instr <= '0;
      ifid_npc   <= '0;
      ifid_valid <= 1'b0;
    end else begin
      if (state == StFetch) begin
        if (halt) begin
          state <= StHalt;
        end else if (redir && !ihit && imemREN) begin
          req_addr <= pc;
          state    <= StDrain;
        end
      end else if (ihit) begin
        // Late data for the abandoned request is discarded.
        state <= StFetch;
      end

      if (redir) begin
        pc         <= exmem_target;
        buf_valid  <= 1'b0;
        ifid_instr <= '0;
        ifid_npc   <= '0;
        ifid_valid <= 1'b0;
      end else if (ifid_flush) begin
        ifid_instr <= '0;
        ifid_npc   <= '0;
        ifid_valid <= 1'b0;
      end else if (advance) begin
        if (buf_valid) begin
          ifid_instr <= buf_instr;
          ifid_npc   <= pc_plus4;
          ifid_valid <= 1'b1;
          pc         <= pc_plus4;
          buf_valid  <= 1'b0;
        end else if (fetch_hit) begin
          ifid_instr <= imemload;
          ifid_npc   <= pc_plus4;
          ifid_valid <= 1'b1;
          pc         <= pc_plus4;
        end else begin
          ifid_instr <= '0;
          ifid_npc   <= '0;
          ifid_valid <= 1'b0;
        end
      end else if (fetch_hit) begin
        buf_instr <= imemload;
        buf_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected IF/ID entries plus point checks.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ifid_en, ifid_flush, mem_stall;
  logic [2:0]  exmem_PCSrc;
  logic        exmem_ZeroFlag;
  logic [31:0] exmem_target;
  logic        halt, ihit;
  logic [31:0] imemload;

  logic        imemREN, ifid_valid;
  logic [31:0] imemaddr, ifid_instr, ifid_npc, pc;
  logic        imemREN2, ifid_valid2;
  logic [31:0] imemaddr2, ifid_instr2, ifid_npc2, pc2;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb[$];

  always #5 CLK = ~CLK;

  fetch_unit #(.WORD_W(32), .PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .mem_stall(mem_stall),
    .exmem_PCSrc(exmem_PCSrc), .exmem_ZeroFlag(exmem_ZeroFlag), .exmem_target(exmem_target),
    .halt(halt), .ihit(ihit), .imemload(imemload), .imemREN(imemREN), .imemaddr(imemaddr),
    .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid), .pc(pc)
  );

  fetch_unit #(.WORD_W(32), .PC_INIT(32'hFFFF_FFFC)) dut_wrap (
    .CLK(CLK), .RST(RST), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .mem_stall(mem_stall),
    .exmem_PCSrc(exmem_PCSrc), .exmem_ZeroFlag(exmem_ZeroFlag), .exmem_target(exmem_target),
    .halt(halt), .ihit(ihit), .imemload(imemload), .imemREN(imemREN2), .imemaddr(imemaddr2),
    .ifid_instr(ifid_instr2), .ifid_npc(ifid_npc2), .ifid_valid(ifid_valid2), .pc(pc2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hA5C3_0000) + 32'h0000_1001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; when IF/ID should have loaded a real instruction, pop and compare it.
  task automatic cyc();
    logic redir_in, adv;
    logic [63:0] e;
    redir_in = (exmem_PCSrc == 3'b001) || (exmem_PCSrc == 3'b010 && exmem_ZeroFlag) ||
               (exmem_PCSrc == 3'b110 && !exmem_ZeroFlag);
    adv = ifid_en && !mem_stall && !ifid_flush && !redir_in && !RST;
    @(posedge CLK);
    #1;
    if (adv && ifid_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_instr", ifid_instr, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", ifid_instr, e[63:32]);
        chk("sb_npc", ifid_npc, e[31:0]);
      end
    end
  endtask

  // Supply a hit at the expected address; it is accepted now or captured into the buffer.
  task automatic hit(input logic [31:0] addr, input bit accepted_now);
    chk("req_addr", imemaddr, addr);
    chk("req_ren", {31'b0, imemREN}, 32'd1);
    ihit     = 1'b1;
    imemload = mem_word(addr);
    sb.push_back({mem_word(addr), addr + 32'd4});
    cyc();
    ihit = 1'b0;
    if (accepted_now) begin
      chk("hit_valid", {31'b0, ifid_valid}, 32'd1);
      chk("hit_pc", pc, addr + 32'd4);
    end
  endtask

  initial begin
    RST = 1'b1; ifid_en = 1'b1; ifid_flush = 1'b0; mem_stall = 1'b0;
    exmem_PCSrc = 3'b000; exmem_ZeroFlag = 1'b0; exmem_target = '0;
    halt = 1'b0; ihit = 1'b0; imemload = '0;
    cyc();
    cyc();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ren", {31'b0, imemREN}, 32'd1);
    chk("rst_addr", imemaddr, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_npc", ifid_npc, 32'h0);
    RST = 1'b0;

    // Continuous hits at 0 and 4.
    hit(32'h0, 1'b1);
    hit(32'h4, 1'b1);

    // Load-use stall for two cycles with a hit at 8: captured, then released once.
    ifid_en = 1'b0;
    hit(32'h8, 1'b0);
    chk("stall_pc", pc, 32'h8);
    chk("stall_ren", {31'b0, imemREN}, 32'd0);
    chk("stall_hold_npc", ifid_npc, 32'h8);
    cyc();
    chk("stall2_pc", pc, 32'h8);
    chk("stall2_ren", {31'b0, imemREN}, 32'd0);
    ifid_en = 1'b1;
    cyc();
    chk("release_valid", {31'b0, ifid_valid}, 32'd1);
    chk("release_pc", pc, 32'hC);
    chk("release_addr", imemaddr, 32'hC);
    chk("release_ren", {31'b0, imemREN}, 32'd1);
    hit(32'hC, 1'b1);

    // Taken beq while fetching 0x10: fetched data dropped, IF/ID cleared.
    exmem_PCSrc = 3'b010; exmem_ZeroFlag = 1'b1; exmem_target = 32'h40;
    ihit = 1'b1; imemload = mem_word(32'h10);
    cyc();
    ihit = 1'b0; exmem_PCSrc = 3'b000; exmem_ZeroFlag = 1'b0;
    chk("beq_valid", {31'b0, ifid_valid}, 32'd0);
    chk("beq_instr", ifid_instr, 32'h0);
    chk("beq_npc", ifid_npc, 32'h0);
    chk("beq_addr", imemaddr, 32'h40);
    hit(32'h40, 1'b1);

    // Not-taken beq: normal flow continues.
    exmem_PCSrc = 3'b010; exmem_ZeroFlag = 1'b0; exmem_target = 32'h80;
    hit(32'h44, 1'b1);
    exmem_PCSrc = 3'b000;

    // Jump to 0x20 while a hit for 0x48 arrives.
    exmem_PCSrc = 3'b001; exmem_target = 32'h20;
    ihit = 1'b1; imemload = mem_word(32'h48);
    cyc();
    ihit = 1'b0; exmem_PCSrc = 3'b000;
    chk("jmp_addr", imemaddr, 32'h20);
    chk("jmp_valid", {31'b0, ifid_valid}, 32'd0);

    // bne taken during a miss at 0x20: request held until its hit, data discarded.
    exmem_PCSrc = 3'b110; exmem_ZeroFlag = 1'b0; exmem_target = 32'h80;
    cyc();
    exmem_PCSrc = 3'b000;
    chk("drain_addr1", imemaddr, 32'h20);
    chk("drain_ren1", {31'b0, imemREN}, 32'd1);
    chk("drain_pc", pc, 32'h80);
    cyc();
    chk("drain_addr2", imemaddr, 32'h20);
    ihit = 1'b1; imemload = mem_word(32'h20);
    cyc();
    ihit = 1'b0;
    chk("drain_dropped", {31'b0, ifid_valid}, 32'd0);
    chk("drain_next_addr", imemaddr, 32'h80);
    hit(32'h80, 1'b1);

    // Flush alone: IF/ID cleared, PC holds, data this cycle not taken.
    ifid_flush = 1'b1; ihit = 1'b1; imemload = mem_word(32'h84);
    cyc();
    ifid_flush = 1'b0; ihit = 1'b0;
    chk("flush_valid", {31'b0, ifid_valid}, 32'd0);
    chk("flush_pc", pc, 32'h84);
    hit(32'h84, 1'b1);

    // Memory stall: hit captured into buffer, released afterwards.
    mem_stall = 1'b1;
    hit(32'h88, 1'b0);
    chk("mstall_pc", pc, 32'h88);
    chk("mstall_ren", {31'b0, imemREN}, 32'd0);
    mem_stall = 1'b0;
    cyc();
    chk("mstall_release_pc", pc, 32'h8C);

    // Halt: fetch stops, PC frozen, even against a redirect.
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("halt_ren", {31'b0, imemREN}, 32'd0);
      chk("halt_pc", pc, 32'h8C);
      chk("halt_valid", {31'b0, ifid_valid}, 32'd0);
      if (i == 4) begin
        exmem_PCSrc = 3'b001; exmem_target = 32'h100;
      end else begin
        exmem_PCSrc = 3'b000;
      end
      cyc();
    end
    exmem_PCSrc = 3'b000;

    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_ren", {31'b0, imemREN}, 32'd1);
    chk("wrap_rst_addr", imemaddr2, 32'hFFFF_FFFC);

    // PC wrap on the second instance; the first takes the same word at 0.
    ihit = 1'b1; imemload = 32'h1234_5678;
    sb.push_back({32'h1234_5678, 32'h4});
    cyc();
    ihit = 1'b0;
    chk("wrap_npc", ifid_npc2, 32'h0);
    chk("wrap_instr", ifid_instr2, 32'h1234_5678);
    chk("wrap_valid", {31'b0, ifid_valid2}, 32'd1);
    chk("wrap_addr", imemaddr2, 32'h0);

    chk("sb_leftover", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
